// File: rtl/pic_window_fetch.sv
// Sliding-window fetch engine: scans FILTERxFILTER windows tile by tile, issues lane reads and
// buffers returning data in a small FIFO. Define PIC_WIN_PAD_EN to enable zero-padded borders.
module pic_window_fetch #(
   parameter int BITS    = 16,
   parameter int CH_NUM  = 1,
   parameter int TILE_H  = 4,
   parameter int TILE_W  = 4,
   parameter int LENGTH  = 60,
   parameter int HEIGHT  = 60,
   parameter int FILTER  = 3,
   parameter int STRIDE  = 4,
   parameter int MEM_LAT = 1,
   parameter int ADDR_W  = 12,
   parameter int PAD     = 1
) (
   input  logic                                   clk_in,
   input  logic                                   rst,
   input  logic                                   start,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   mem_rd_en,
   output logic [CH_NUM*TILE_H*TILE_W*ADDR_W-1:0] mem_addr,
   input  logic [CH_NUM*TILE_H*TILE_W*BITS-1:0]   mem_rdata,
   output logic [CH_NUM*TILE_H*TILE_W*BITS-1:0]   map,
   output logic                                   map_valid,
   input  logic                                   map_ready,
   output logic                                   map_last
);

   localparam int LANES = CH_NUM*TILE_H*TILE_W;
   localparam int DEPTH = MEM_LAT + 2;
`ifdef PIC_WIN_PAD_EN
   localparam int PAD_EFF = PAD;
`else
   localparam int PAD_EFF = PAD * 0;
`endif
   localparam int ROW_SPAN = HEIGHT + 2*PAD_EFF - FILTER - TILE_H + 1;
   localparam int COL_SPAN = LENGTH + 2*PAD_EFF - FILTER - TILE_W + 1;
   localparam logic [15:0] ROW_LAST = 16'((ROW_SPAN / STRIDE) * STRIDE);
   localparam logic [15:0] COL_LAST = 16'((COL_SPAN / STRIDE) * STRIDE);
   localparam logic [15:0] OFF_LAST = 16'(FILTER - 1);
   localparam logic [15:0] STEP     = 16'(STRIDE);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

   state_t                     state_r, state_next_s;
   logic                       busy_r, done_r, rd_en_r, map_valid_r;
   logic                       issue_s, fin_s, done_s, room_s, push_s, pop_s;
   logic [15:0]                row_off_r, col_off_r, col_org_r, row_org_r;
   logic [LANES*ADDR_W-1:0]    addr_r, addr_s;
   logic [LANES-1:0]           mask_s, req_mask_r;
   logic                       req_last_r;
   logic                       pipe_vld_r  [MEM_LAT];
   logic                       pipe_last_r [MEM_LAT];
   logic [LANES-1:0]           pipe_mask_r [MEM_LAT];
   logic [LANES*BITS-1:0]      push_data_s;
   logic [LANES*BITS-1:0]      fifo_data_r [DEPTH];
   logic [LANES*BITS-1:0]      fifo_data_s [DEPTH];
   logic [LANES*BITS-1:0]      shift_data_s [DEPTH];
   logic                       fifo_last_r [DEPTH];
   logic                       fifo_last_s [DEPTH];
   logic                       shift_last_s [DEPTH];
   logic [3:0]                 cnt_r, infl_r, cnt_next_s, infl_next_s, wr_idx_s;

   assign fin_s  = (row_off_r == OFF_LAST) && (col_off_r == OFF_LAST) &&
                   (col_org_r == COL_LAST) && (row_org_r == ROW_LAST);
   assign push_s = pipe_vld_r[MEM_LAT-1];
   assign pop_s  = map_valid_r & map_ready;
   // A read may only go out if its data is guaranteed a FIFO slot on return.
   assign room_s = ({1'b0, cnt_r} + {1'b0, infl_r}) < (5'(DEPTH) + {4'b0, pop_s});
   assign wr_idx_s    = cnt_r - {3'b0, pop_s};
   assign cnt_next_s  = cnt_r + {3'b0, push_s} - {3'b0, pop_s};
   assign infl_next_s = infl_r + {3'b0, issue_s} - {3'b0, push_s};

   // FSM state register
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_next_s;
   end

   // FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE:    if (start) state_next_s = fin_s ? DRAIN : ISSUE; else state_next_s = IDLE;
         ISSUE:   if (issue_s && fin_s) state_next_s = DRAIN; else state_next_s = ISSUE;
         DRAIN:   if (cnt_r == 4'd0 && infl_r == 4'd0) state_next_s = IDLE; else state_next_s = DRAIN;
         default: state_next_s = IDLE;
      endcase
   end

   // FSM outputs: read issue and completion strobe
   always_comb begin
      issue_s = 1'b0;
      done_s  = 1'b0;
      case (state_r)
         IDLE:    issue_s = start;
         ISSUE:   issue_s = room_s;
         DRAIN:   done_s  = (cnt_r == 4'd0) && (infl_r == 4'd0);
         default: issue_s = 1'b0;
      endcase
   end

   // Per-lane addresses and out-of-map flags for the current scan position
   always_comb begin
      int row_s, col_s, n_s;
      row_s  = 0;
      col_s  = 0;
      n_s    = 0;
      addr_s = '0;
      mask_s = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         for (int j = 0; j < TILE_H; j++) begin
            for (int k = 0; k < TILE_W; k++) begin
               n_s   = (c*TILE_H + j)*TILE_W + k;
               row_s = int'(row_org_r) + int'(row_off_r) + j - PAD_EFF;
               col_s = int'(col_org_r) + int'(col_off_r) + k - PAD_EFF;
               if (row_s < 0 || row_s >= HEIGHT || col_s < 0 || col_s >= LENGTH) mask_s[n_s] = 1'b1;
               else mask_s[n_s] = 1'b0;
               addr_s[n_s*ADDR_W +: ADDR_W] = ADDR_W'(c*LENGTH*HEIGHT + row_s*LENGTH + col_s);
            end
         end
      end
   end

   // Scan counters, read strobe and request side-band
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         row_off_r  <= 16'd0;
         col_off_r  <= 16'd0;
         col_org_r  <= 16'd0;
         row_org_r  <= 16'd0;
         rd_en_r    <= 1'b0;
         addr_r     <= '0;
         req_last_r <= 1'b0;
         req_mask_r <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         rd_en_r <= issue_s;
         busy_r  <= (state_next_s != IDLE);
         done_r  <= done_s;
         if (issue_s) begin
            addr_r     <= addr_s;
            req_mask_r <= mask_s;
            req_last_r <= (row_off_r == OFF_LAST) && (col_off_r == OFF_LAST);
            if (row_off_r == OFF_LAST) begin
               row_off_r <= 16'd0;
               if (col_off_r == OFF_LAST) begin
                  col_off_r <= 16'd0;
                  if (col_org_r == COL_LAST) begin
                     col_org_r <= 16'd0;
                     row_org_r <= (row_org_r == ROW_LAST) ? 16'd0 : row_org_r + STEP;
                  end else col_org_r <= col_org_r + STEP;
               end else col_off_r <= col_off_r + 16'd1;
            end else row_off_r <= row_off_r + 16'd1;
         end
      end
   end

   // Side-band delay line matching the memory latency
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MEM_LAT; i++) begin
            pipe_vld_r[i]  <= 1'b0;
            pipe_last_r[i] <= 1'b0;
            pipe_mask_r[i] <= '0;
         end
      end else begin
         pipe_vld_r[0]  <= rd_en_r;
         pipe_last_r[0] <= req_last_r;
         pipe_mask_r[0] <= req_mask_r;
         for (int i = 1; i < MEM_LAT; i++) begin
            pipe_vld_r[i]  <= pipe_vld_r[i-1];
            pipe_last_r[i] <= pipe_last_r[i-1];
            pipe_mask_r[i] <= pipe_mask_r[i-1];
         end
      end
   end

   // Returned data with padded lanes forced to zero
   always_comb begin
      push_data_s = '0;
      for (int n = 0; n < LANES; n++) begin
         if (pipe_mask_r[MEM_LAT-1][n]) push_data_s[n*BITS +: BITS] = '0;
         else push_data_s[n*BITS +: BITS] = mem_rdata[n*BITS +: BITS];
      end
   end

   // FIFO next contents: head at slot 0, pops shift down and zero-fill the top
   always_comb begin
      for (int i = 0; i < DEPTH-1; i++) begin
         shift_data_s[i] = fifo_data_r[i+1];
         shift_last_s[i] = fifo_last_r[i+1];
      end
      shift_data_s[DEPTH-1] = '0;
      shift_last_s[DEPTH-1] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (push_s && wr_idx_s == 4'(i)) begin
            fifo_data_s[i] = push_data_s;
            fifo_last_s[i] = pipe_last_r[MEM_LAT-1];
         end else if (pop_s) begin
            fifo_data_s[i] = shift_data_s[i];
            fifo_last_s[i] = shift_last_s[i];
         end else begin
            fifo_data_s[i] = fifo_data_r[i];
            fifo_last_s[i] = fifo_last_r[i];
         end
      end
   end

   // FIFO storage, occupancy and in-flight tracking
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data_r[i] <= '0;
            fifo_last_r[i] <= 1'b0;
         end
         cnt_r       <= 4'd0;
         infl_r      <= 4'd0;
         map_valid_r <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data_r[i] <= fifo_data_s[i];
            fifo_last_r[i] <= fifo_last_s[i];
         end
         cnt_r       <= cnt_next_s;
         infl_r      <= infl_next_s;
         map_valid_r <= (cnt_next_s != 4'd0);
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign mem_rd_en = rd_en_r;
   assign mem_addr  = addr_r;
   assign map       = fifo_data_r[0];
   assign map_last  = fifo_last_r[0];
   assign map_valid = map_valid_r;

endmodule

// File: tb/tb_pic_window_fetch.sv
// Scoreboard bench for pic_window_fetch: window scan model, address-echo memory, random back-pressure.
module tb_pic_window_fetch;

   localparam int BITS = 16, CH = 2, TH = 2, TW = 2, LEN = 8, HGT = 8;
   localparam int FIL = 3, STR = 2, LAT = 3, AW = 12, PAD = 1;
   localparam int LANES = CH*TH*TW;
   localparam int MW = LANES*BITS;
`ifdef PIC_WIN_PAD_EN
   localparam int P = PAD;
   localparam int EXP_WIN = 16;
`else
   localparam int P = 0;
   localparam int EXP_WIN = 9;
`endif
   localparam int EXP_BEATS = EXP_WIN*FIL*FIL;

   logic               clk_in = 1'b0, rst = 1'b1, start = 1'b0, map_ready = 1'b1;
   logic               busy, done, mem_rd_en, map_valid, map_last;
   logic [LANES*AW-1:0] mem_addr;
   logic [MW-1:0]      mem_rdata, map;
   logic [LANES*AW-1:0] mem_pipe [LAT];

   int tests = 0, fails = 0;
   int beats_seen = 0, lasts_seen = 0;
   logic [MW-1:0] exp_map [$];
   logic          exp_last [$];
   logic [MW-1:0] first_map, second_map, prev_map;
   logic          prev_last, prev_stall = 1'b0;

   pic_window_fetch #(.BITS(BITS), .CH_NUM(CH), .TILE_H(TH), .TILE_W(TW), .LENGTH(LEN),
      .HEIGHT(HGT), .FILTER(FIL), .STRIDE(STR), .MEM_LAT(LAT), .ADDR_W(AW), .PAD(PAD)) dut (
      .clk_in(clk_in), .rst(rst), .start(start), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .map(map),
      .map_valid(map_valid), .map_ready(map_ready), .map_last(map_last));

   always #5 clk_in = ~clk_in;

   // Memory returns each lane's address as data, LAT cycles after the strobe; junk otherwise
   always @(posedge clk_in) begin
      mem_pipe[0] <= mem_rd_en ? mem_addr : {$urandom(), $urandom(), $urandom()};
      for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
   end
   always_comb begin
      mem_rdata = '0;
      for (int n = 0; n < LANES; n++)
         mem_rdata[n*BITS +: BITS] = {{(BITS-AW){1'b0}}, mem_pipe[LAT-1][n*AW +: AW]};
   end

   task automatic check_i(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic check_w(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Reference: every window in scan order, each lane = linear address or 0 outside the map
   task automatic push_expected();
      for (int ro = 0; ro + FIL - 1 + TH - 1 <= HGT - 1 + 2*P; ro += STR)
         for (int co = 0; co + FIL - 1 + TW - 1 <= LEN - 1 + 2*P; co += STR)
            for (int cf = 0; cf < FIL; cf++)
               for (int rf = 0; rf < FIL; rf++) begin
                  logic [MW-1:0] v;
                  v = '0;
                  for (int c = 0; c < CH; c++)
                     for (int j = 0; j < TH; j++)
                        for (int k = 0; k < TW; k++) begin
                           int r, cc, n;
                           r  = ro + rf + j - P;
                           cc = co + cf + k - P;
                           n  = (c*TH + j)*TW + k;
                           if (r >= 0 && r < HGT && cc >= 0 && cc < LEN)
                              v[n*BITS +: BITS] = BITS'((c*LEN*HGT + r*LEN + cc) % (1 << AW));
                        end
                  exp_map.push_back(v);
                  exp_last.push_back(rf == FIL-1 && cf == FIL-1);
               end
   endtask

   function automatic logic [MW-1:0] lanes_vec(input int a0, a1, a2, a3, a4, a5, a6, a7);
      logic [MW-1:0] v;
      int vals [8];
      vals = '{a0, a1, a2, a3, a4, a5, a6, a7};
      v = '0;
      for (int n = 0; n < 8; n++) v[n*BITS +: BITS] = BITS'(vals[n]);
      return v;
   endfunction

   // Monitor: pops the scoreboard on every accepted beat and checks stall stability
   always @(negedge clk_in) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_i("hold_valid", int'(map_valid), 1);
            check_w("hold_map", map, prev_map);
            check_i("hold_last", int'(map_last), int'(prev_last));
         end
         if (map_valid && map_ready) begin
            if (exp_map.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_beat: got beat %0h expected none", map);
            end else begin
               logic [MW-1:0] em;
               logic el;
               em = exp_map.pop_front();
               el = exp_last.pop_front();
               check_w("beat_map", map, em);
               check_i("beat_last", int'(map_last), int'(el));
            end
`ifndef PIC_WIN_PAD_EN
            for (int n = 0; n < TH*TW; n++)
               check_i("ch1_offset", int'(map[(n+TH*TW)*BITS +: BITS]),
                       int'(map[n*BITS +: BITS]) + LEN*HGT);
`endif
            if (beats_seen == 0) first_map = map;
            if (beats_seen == 1) second_map = map;
            beats_seen++;
            if (map_last) lasts_seen++;
         end
         prev_stall = map_valid && !map_ready;
         prev_map   = map;
         prev_last  = map_last;
      end
   end

   task automatic do_start();
      @(posedge clk_in); #1 start = 1'b1;
      @(posedge clk_in); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int got;
      got = 0;
      for (int i = 0; i < budget && got == 0; i++) begin
         @(posedge clk_in); #1;
         if (done) got = 1;
      end
      check_i(tag, got, 1);
      @(posedge clk_in); #1;
      check_i("done_pulse", int'(done), 0);
      check_i("busy_after_done", int'(busy), 0);
   endtask

   task automatic check_run_totals(input string tag);
      check_i({tag, "_beats"}, beats_seen, EXP_BEATS);
      check_i({tag, "_lasts"}, lasts_seen, EXP_WIN);
      check_i({tag, "_leftover"}, exp_map.size(), 0);
   endtask

   task automatic check_quiet_outputs(input string tag);
      check_i({tag, "_busy"}, int'(busy), 0);
      check_i({tag, "_done"}, int'(done), 0);
      check_i({tag, "_rd_en"}, int'(mem_rd_en), 0);
      check_i({tag, "_valid"}, int'(map_valid), 0);
      check_i({tag, "_last"}, int'(map_last), 0);
      check_w({tag, "_map"}, map, '0);
      check_i({tag, "_addr"}, int'(mem_addr != '0), 0);
   endtask

   initial begin
      int lat, run, rds, seen;
      repeat (3) @(posedge clk_in);
      #1 check_quiet_outputs("reset");
      rst = 1'b0;

      // Run A: full throughput, latency and first beats
      push_expected();
      beats_seen = 0; lasts_seen = 0; map_ready = 1'b1;
      do_start();
      check_i("busy_on_start", int'(busy), 1);
      lat = 0;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
         @(posedge clk_in); #1;
         if (map_valid) lat = n;
      end
      check_i("first_valid_latency", lat, LAT + 1);
      run = 1;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk_in); #1;
         if (!map_valid) break;
         run++;
      end
      check_i("contiguous_beats", run, EXP_BEATS);
      wait_done(50, "runA_done");
      check_run_totals("runA");
`ifdef PIC_WIN_PAD_EN
      check_w("first_beat", first_map, lanes_vec(0, 0, 0, 0, 0, 0, 0, 64));
      check_w("second_beat", second_map, lanes_vec(0, 0, 0, 8, 0, 64, 0, 72));
`else
      check_w("first_beat", first_map, lanes_vec(0, 1, 8, 9, 64, 65, 72, 73));
      check_w("second_beat", second_map, lanes_vec(8, 9, 16, 17, 72, 73, 80, 81));
`endif

      // Run B: random back-pressure, plus a start pulse while busy
      push_expected();
      beats_seen = 0; lasts_seen = 0;
      do_start();
      seen = 0;
      for (int cyc = 0; cyc < 3000 && seen == 0; cyc++) begin
         @(posedge clk_in); #1;
         if (done) seen = 1;
         map_ready = 1'($urandom_range(0, 1));
         start = (cyc == 30 || cyc == 31);
      end
      start = 1'b0; map_ready = 1'b1;
      check_i("runB_done", seen, 1);
      repeat (20) @(posedge clk_in);
      #1 check_i("runB_no_restart", int'(busy), 0);
      check_run_totals("runB");

      // Run C: consumer stalled for 20 cycles after start
      push_expected();
      beats_seen = 0; lasts_seen = 0; map_ready = 1'b0;
      do_start();
      rds = 0;
      for (int i = 0; i < 20; i++) begin
         if (mem_rd_en) rds++;
         @(posedge clk_in); #1;
      end
      check_i("stall_reads_bounded", int'(rds <= LAT + 2), 1);
      check_i("stall_reads_started", int'(rds > 0), 1);
      check_i("stall_valid_held", int'(map_valid), 1);
      map_ready = 1'b1;
      wait_done(1000, "runC_done");
      check_run_totals("runC");

      // Run D: reset in the middle of a fetch, then a clean run
      push_expected();
      beats_seen = 0; lasts_seen = 0;
      do_start();
      seen = 0;
      for (int i = 0; i < 500 && seen == 0; i++) begin
         @(posedge clk_in); #1;
         if (beats_seen >= 40) seen = 1;
      end
      check_i("runD_reached_40", seen, 1);
      rst = 1'b1;
      exp_map.delete();
      exp_last.delete();
      @(posedge clk_in); #1;
      check_quiet_outputs("midrst");
      @(posedge clk_in); #1 rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk_in); #1;
         if (map_valid) seen++;
      end
      check_i("no_valid_after_rst", seen, 0);
      push_expected();
      beats_seen = 0; lasts_seen = 0;
      do_start();
      wait_done(1000, "runD_done");
      check_run_totals("runD");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pic_window_fetch.md
PIC_WINDOW_FETCH -- requirements
Module: pic_window_fetch

Interface
REQ-001 SHALL have parameter BITS, default 16, meaning pixel width in bits.
REQ-002 SHALL have parameter CH_NUM, default 1, meaning input channel count.
REQ-003 SHALL have parameter TILE_H, default 4, and TILE_W, default 4, meaning parallel lane tile height and width; LANES = CH_NUM*TILE_H*TILE_W.
REQ-004 SHALL have parameter LENGTH, default 60, and HEIGHT, default 60, meaning feature-map width and height.
REQ-005 SHALL have parameter FILTER, default 3, meaning kernel size (FILTER x FILTER); parameter STRIDE, default 4, meaning window step.
REQ-006 SHALL have parameter MEM_LAT, default 1, meaning fixed read latency in cycles (1..4); parameter ADDR_W, default 12, meaning word-address width.
REQ-007 SHALL have parameter PAD, default 1, meaning zero-padding border width, used only with PIC_WIN_PAD_EN.
REQ-008 clk_in  in  1  single clock; all logic on rising edge.
REQ-009 rst  in  1  reset, asynchronous, active-high.
REQ-010 start  in  1  one-cycle request to fetch the whole map; ignored while busy.
REQ-011 busy  out  1  high from accepted start until done.
REQ-012 done  out  1  one-cycle pulse after the last beat is accepted.
REQ-013 mem_rd_en  out  1  read strobe for all lanes.
REQ-014 mem_addr  out  LANES*ADDR_W  per-lane word address.
REQ-015 mem_rdata  in  LANES*BITS  per-lane data, valid MEM_LAT cycles after mem_rd_en.
REQ-016 map  out  LANES*BITS  output tile; lane n at bits [n*BITS +: BITS].
REQ-017 map_valid / map_ready  out / in  1 / 1  output handshake; beat transfers when both are high.
REQ-018 map_last  out  1  high on the final beat of each window (offset FILTER-1, FILTER-1).

Function
REQ-019 SHALL implement states IDLE, ISSUE and DRAIN: IDLE->ISSUE on start; ISSUE->DRAIN after the final read is issued; DRAIN->IDLE when the FIFO and in-flight count are both zero.
REQ-020 Scan order SHALL be: row offset innermost, then column offset, then column origin, then row origin; offsets run 0..FILTER-1 and origins step by STRIDE.
REQ-021 Valid origins SHALL satisfy origin+FILTER-1+TILE-1 <= dim-1 per axis; the origin resets to 0 when the next step would violate this.
REQ-022 Lane (c,j,k) address SHALL be c*LENGTH*HEIGHT + (row_org+row_off+j)*LENGTH + col_org+col_off+k, truncated to ADDR_W.
REQ-023 Return data SHALL enter a FIFO of depth MEM_LAT+2; mem_rd_en SHALL assert only when FIFO occupancy plus in-flight reads < depth, so no beat is lost under map_ready=0.
REQ-024 With map_ready held high, the core SHALL issue one read per cycle; the first map_valid SHALL appear MEM_LAT+1 cycles after start.
REQ-025 map, map_valid and map_last SHALL hold stable while map_valid=1 and map_ready=0.
REQ-026 map_last SHALL travel through the FIFO alongside its data.
REQ-027 start asserted while busy SHALL have no effect.
REQ-028 Simultaneous push and pop on a full FIFO SHALL be legal, and occupancy SHALL remain unchanged.

Reset
REQ-029 rst SHALL force IDLE and clear all counters, the FIFO and the in-flight count.
REQ-030 While rst is high, busy, done, mem_rd_en, map_valid and map_last SHALL be 0, and map and mem_addr SHALL be 0.
REQ-031 rst asserted mid-fetch SHALL discard data still returning from memory; no map_valid SHALL appear until the next start.

Configuration
REQ-032 With PIC_WIN_PAD_EN defined, coordinates SHALL be offset by -PAD, the origin range SHALL extend by 2*PAD per axis, and out-of-map lanes SHALL output 0 without relying on memory data.
REQ-033 Without PIC_WIN_PAD_EN, PAD SHALL be ignored and REQ-021/022 SHALL apply unmodified.

Verification
Verification benches SHALL use a memory model returning data = address.
REQ-034 LENGTH=8, HEIGHT=8, FILTER=3, STRIDE=2, TILE 2x2, CH_NUM=1, map_ready=1 -> 9 windows, 81 beats, 9 map_last, then done; beat 0 lanes = {0,1,8,9}.
REQ-035 Same setup, map_ready toggled randomly at 50% -> identical 81-beat sequence with no drops or duplicates; beats hold while stalled.
REQ-036 MEM_LAT=3, map_ready=0 for 20 cycles after start -> at most 5 reads issued; the remaining reads resume after map_ready rises.
REQ-037 rst pulsed at beat 40 -> all outputs 0, no map_valid until a new start; the new run produces a full 81 beats.
REQ-038 With PIC_WIN_PAD_EN and PAD=1 -> 16 windows; first beat lanes = {0,0,0,0}; second beat lanes = {0,0,0,8}.
REQ-039 CH_NUM=2 -> channel 1 lanes equal channel 0 lanes + 64 on every beat.
